fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded at reset.
REQ-002 SHALL have parameter BUBBLE, default 16'h0000, instruction word inserted into IF/ID on flush/halt (NOP).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc_sel  input  1  0 = sequential PC+2, 1 = redirect to branch_target.
REQ-006 SHALL have port branch_target  input  16  resolved branch/jump address from EX.
REQ-007 SHALL have port pc_stop  input  1  hazard-unit PC hold.
REQ-008 SHALL have port if_id_hold  input  1  hazard-unit IF/ID hold.
REQ-009 SHALL have port if_id_flush  input  1  control-unit IF/ID flush.
REQ-010 SHALL have port halt  input  1  halt request from control unit.
REQ-011 SHALL have port imem_data  input  16  instruction read combinationally at imem_addr.
REQ-012 SHALL have port imem_addr  output  16  current PC, drives instruction memory.
REQ-013 SHALL have port pc_plus2  output  16  combinational PC+2.
REQ-014 SHALL have port id_instruction  output  16  IF/ID instruction register.
REQ-015 SHALL have port id_pc_next  output  16  IF/ID copy of PC+2 of the held instruction.
REQ-016 SHALL have port id_valid  output  1  1 when id_instruction is a real fetched instruction.
REQ-017 SHALL have port halted  output  1  1 while in HALT state.
REQ-018 SHALL have port misalign_err  output  1  sticky flag, odd redirect target seen.
REQ-019 SHALL have port fetch_count  output  16  count of instructions loaded into IF/ID.

Function
REQ-020 SHALL implement two states RUN and HALT; RUN -> HALT on clock edge where halt=1; HALT exits only by reset.
REQ-021 SHALL compute pc_plus2 = PC + 2 modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-022 SHALL update PC with priority: HALT state or halt=1 -> hold; else pc_sel=1 -> {branch_target[15:1],1'b0}; else pc_stop=1 -> hold; else pc_plus2.
REQ-023 SHALL let pc_sel override pc_stop in the same cycle (stalled instruction is discarded).
REQ-024 SHALL update IF/ID with priority: HALT state or halt=1 -> BUBBLE, id_valid=0; else if_id_flush=1 -> BUBBLE, id_valid=0, id_pc_next=0; else if_id_hold=1 -> hold all; else imem_data, pc_plus2, id_valid=1.
REQ-025 SHALL set misalign_err on any edge where pc_sel=1 and branch_target[0]=1 in RUN; cleared only by reset.
REQ-026 SHALL increment fetch_count on each edge loading a real instruction (id_valid set 1 by REQ-024 last case); saturate at 16'hFFFF.
REQ-027 SHALL give one-cycle latency: imem_data at PC in cycle n appears on id_instruction in cycle n+1.
REQ-028 SHALL keep imem_addr = PC in all states, including HALT.

Reset
REQ-029 SHALL, on edge with reset=0, set PC=RESET_PC, id_instruction=BUBBLE, id_pc_next=0, id_valid=0, state=RUN, halted=0, misalign_err=0, fetch_count=0, overriding all other inputs including mid-halt or mid-stall.

Verification
REQ-030 Sequential: reset, then 3 edges with imem_data=16'h1234 -> imem_addr 0000,0002,0004,0006; id_pc_next=0006; fetch_count=3.
REQ-031 Stall: PC=0004, pc_stop=1 and if_id_hold=1 for 2 edges -> imem_addr stays 0004, id_instruction unchanged, fetch_count unchanged.
REQ-032 Redirect+flush: PC=0010, pc_sel=1, branch_target=0041, if_id_flush=1, pc_stop=1 -> PC=0040, id_instruction=0000, id_valid=0, misalign_err=1.
REQ-033 Wrap: PC=FFFE, no stall -> next PC=0000, id_pc_next=0000.
REQ-034 Halt: halt=1 at PC=0020 -> halted=1 next edge, PC holds 0020, id_valid=0 for all later edges despite pc_sel=1; reset=0 -> PC=0000, halted=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Handles redirect, stall, flush and halt, and keeps fetch statistics.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] BUBBLE   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [15:0] branch_target,
  input  logic        pc_stop,
  input  logic        if_id_hold,
  input  logic        if_id_flush,
  input  logic        halt,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] pc_plus2,
  output logic [15:0] id_instruction,
  output logic [15:0] id_pc_next,
  output logic        id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  localparam int unsigned W = 16;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   instr_q, instr_d;
  logic [W-1:0]   pcn_q, pcn_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           halted_q, halted_d;
  logic           mis_q, mis_d;
  logic           frozen;

  assign pc_plus2 = pc_q + W'(2);

  // Next-state: PC and IF/ID priority chains, halt FSM, sticky/stat updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcn_d    = pcn_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    frozen   = (state_q == S_HALT) || halt;

    if ((state_q == S_RUN) && halt) begin
      state_d = S_HALT;
    end
    halted_d = (state_d == S_HALT);

    if (frozen) begin
      pc_d = pc_q;
    end else if (pc_sel) begin
      pc_d = {branch_target[W-1:1], 1'b0};
    end else if (!pc_stop) begin
      pc_d = pc_plus2;
    end

    // id_pc_next is left untouched by halt bubbles; only flush zeroes it
    if (frozen) begin
      instr_d = BUBBLE;
      valid_d = 1'b0;
    end else if (if_id_flush) begin
      instr_d = BUBBLE;
      valid_d = 1'b0;
      pcn_d   = '0;
    end else if (!if_id_hold) begin
      instr_d = imem_data;
      pcn_d   = pc_plus2;
      valid_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + W'(1);
      end
    end

    if ((state_q == S_RUN) && pc_sel && branch_target[0]) begin
      mis_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= BUBBLE;
      pcn_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcn_q    <= pcn_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign id_instruction = instr_q;
  assign id_pc_next     = pcn_q;
  assign id_valid       = valid_q;
  assign halted         = halted_q;
  assign misalign_err   = mis_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, random run against a
// behavioural model, and a fetch-counter saturation sequence.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_sel;
  logic [15:0] branch_target;
  logic        pc_stop;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        halt;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] pc_plus2;
  logic [15:0] id_instruction;
  logic [15:0] id_pc_next;
  logic        id_valid;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic        use_mem;
  logic [15:0] imem_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Instruction memory contents are a fixed scramble of the address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  assign imem_data = use_mem ? mem_word(imem_addr) : imem_v;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .pc_stop       (pc_stop),
    .if_id_hold    (if_id_hold),
    .if_id_flush   (if_id_flush),
    .halt          (halt),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .pc_plus2      (pc_plus2),
    .id_instruction(id_instruction),
    .id_pc_next    (id_pc_next),
    .id_valid      (id_valid),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic        rst_n;
    logic        sel;
    logic [15:0] bt;
    logic        stop;
    logic        hold;
    logic        flush;
    logic        hlt;
    logic [15:0] imem;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pcn;
    logic        e_valid;
    logic        e_halted;
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [15:0] b, input logic st,
                       input logic ho, input logic fl, input logic hl);
    reset = r; pc_sel = s; branch_target = b; pc_stop = st;
    if_id_hold = ho; if_id_flush = fl; halt = hl;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Behavioural model state
  logic [15:0] m_pc, m_instr, m_pcn, m_cnt;
  logic        m_valid, m_halted, m_mis;

  task automatic model_reset;
    m_pc = 16'h0000; m_instr = 16'h0000; m_pcn = 16'h0000; m_cnt = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [15:0] b, input logic st,
                            input logic ho, input logic fl, input logic hl, input logic [15:0] word);
    int seq;
    bit was_halted;
    if (!r) begin
      model_reset();
      return;
    end
    was_halted = m_halted;
    seq = (int'(m_pc) + 2) % 65536;
    if (!was_halted && s && b[0]) m_mis = 1'b1;
    if (was_halted || hl) begin
      m_halted = 1'b1;
      m_instr  = 16'h0000;
      m_valid  = 1'b0;
    end else begin
      if (s)        m_pc = b & 16'hFFFE;
      else if (!st) m_pc = 16'(seq);
      if (fl) begin
        m_instr = 16'h0000; m_valid = 1'b0; m_pcn = 16'h0000;
      end else if (!ho) begin
        m_instr = word; m_pcn = 16'(seq); m_valid = 1'b1;
        if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".imem_addr"},      imem_addr,              m_pc);
    chk({tag, ".pc_plus2"},       pc_plus2,               16'((int'(m_pc) + 2) % 65536));
    chk({tag, ".id_instruction"}, id_instruction,         m_instr);
    chk({tag, ".id_pc_next"},     id_pc_next,             m_pcn);
    chk({tag, ".id_valid"},       16'(id_valid),          16'(m_valid));
    chk({tag, ".halted"},         16'(halted),            16'(m_halted));
    chk({tag, ".misalign_err"},   16'(misalign_err),      16'(m_mis));
    chk({tag, ".fetch_count"},    fetch_count,            m_cnt);
  endtask

  initial begin
    use_mem = 1'b0;
    imem_v  = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    //          rst sel bt        stp hld fls hlt imem       addr      instr     pcn       v  h  m  cnt
    vecs[0]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'd0};
    vecs[1]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 0, 16'd1};
    vecs[2]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0, 0, 16'd2};
    vecs[3]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1, 0, 0, 16'd3};
    vecs[4]  = '{1, 1, 16'h0004, 0, 0, 0, 0, 16'h5555, 16'h0004, 16'h5555, 16'h0008, 1, 0, 0, 16'd4};
    vecs[5]  = '{1, 0, 16'h0000, 1, 1, 0, 0, 16'h7777, 16'h0004, 16'h5555, 16'h0008, 1, 0, 0, 16'd4};
    vecs[6]  = '{1, 0, 16'h0000, 1, 1, 0, 0, 16'h7777, 16'h0004, 16'h5555, 16'h0008, 1, 0, 0, 16'd4};
    vecs[7]  = '{1, 1, 16'h0010, 0, 0, 0, 0, 16'h2222, 16'h0010, 16'h2222, 16'h0006, 1, 0, 0, 16'd5};
    vecs[8]  = '{1, 1, 16'h0041, 1, 0, 1, 0, 16'h3333, 16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 16'd5};
    vecs[9]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 16'h4444, 16'h0042, 16'h4444, 16'h0042, 1, 0, 1, 16'd6};
    vecs[10] = '{1, 1, 16'hFFFE, 0, 0, 0, 0, 16'h0101, 16'hFFFE, 16'h0101, 16'h0044, 1, 0, 1, 16'd7};
    vecs[11] = '{1, 0, 16'h0000, 0, 0, 0, 0, 16'h0202, 16'h0000, 16'h0202, 16'h0000, 1, 0, 1, 16'd8};
    vecs[12] = '{1, 1, 16'h0020, 0, 0, 0, 0, 16'h0303, 16'h0020, 16'h0303, 16'h0002, 1, 0, 1, 16'd9};
    vecs[13] = '{1, 0, 16'h0000, 0, 0, 0, 1, 16'h0404, 16'h0020, 16'h0000, 16'h0002, 0, 1, 1, 16'd9};
    vecs[14] = '{1, 1, 16'h0100, 0, 0, 0, 0, 16'h0505, 16'h0020, 16'h0000, 16'h0002, 0, 1, 1, 16'd9};
    vecs[15] = '{0, 1, 16'h0100, 1, 1, 0, 1, 16'h0505, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'd0};
    vecs[16] = '{1, 0, 16'h0007, 0, 0, 0, 0, 16'h0606, 16'h0002, 16'h0606, 16'h0002, 1, 0, 0, 16'd1};
    vecs[17] = '{1, 0, 16'h0000, 0, 1, 0, 0, 16'h0707, 16'h0004, 16'h0606, 16'h0002, 1, 0, 0, 16'd1};
    vecs[18] = '{1, 0, 16'h0000, 1, 0, 0, 0, 16'h0808, 16'h0004, 16'h0808, 16'h0006, 1, 0, 0, 16'd2};
    vecs[19] = '{1, 0, 16'h0000, 0, 1, 1, 0, 16'h0909, 16'h0006, 16'h0000, 16'h0000, 0, 0, 0, 16'd2};

    // Directed table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst_n, vecs[i].sel, vecs[i].bt, vecs[i].stop,
            vecs[i].hold, vecs[i].flush, vecs[i].hlt);
      imem_v = vecs[i].imem;
      tick();
      chk($sformatf("vec%0d.imem_addr", i),      imem_addr,          vecs[i].e_addr);
      chk($sformatf("vec%0d.pc_plus2", i),       pc_plus2,           vecs[i].e_addr + 16'd2);
      chk($sformatf("vec%0d.id_instruction", i), id_instruction,     vecs[i].e_instr);
      chk($sformatf("vec%0d.id_pc_next", i),     id_pc_next,         vecs[i].e_pcn);
      chk($sformatf("vec%0d.id_valid", i),       16'(id_valid),      16'(vecs[i].e_valid));
      chk($sformatf("vec%0d.halted", i),         16'(halted),        16'(vecs[i].e_halted));
      chk($sformatf("vec%0d.misalign_err", i),   16'(misalign_err),  16'(vecs[i].e_mis));
      chk($sformatf("vec%0d.fetch_count", i),    fetch_count,        vecs[i].e_cnt);
    end

    // Randomised run against the model, memory driven from the address
    use_mem = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    model_reset();
    check_model("rnd_reset");
    for (int c = 0; c < 2000; c++) begin
      logic r, s, st, ho, fl, hl;
      logic [15:0] b, w;
      r  = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 5) == 0);
      b  = 16'($urandom);
      st = ($urandom_range(0, 3) == 0);
      ho = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 6) == 0);
      hl = ($urandom_range(0, 59) == 0);
      w  = mem_word(m_pc);
      drive(r, s, b, st, ho, fl, hl);
      tick();
      model_edge(r, s, b, st, ho, fl, hl, w);
      check_model($sformatf("rnd%0d", c));
    end

    // Fetch counter saturation
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 65540; k++) begin
      tick();
      if (k == 65534) chk("sat.cnt_fffe", fetch_count, 16'hFFFE);
      if (k == 65535) chk("sat.cnt_ffff", fetch_count, 16'hFFFF);
    end
    chk("sat.cnt_held", fetch_count, 16'hFFFF);
    chk("sat.valid",    16'(id_valid), 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
